// File: rtl/vid_pkg.sv
// Shared widths and payload types for the display timing generator.
package vid_pkg;

  localparam int unsigned CW  = 13;
  localparam int unsigned PDW = 6;
  localparam int unsigned CDW = 8;

  typedef struct packed {
    logic [CW-1:0] hend;
    logic [CW-1:0] hsize;
    logic [CW-1:0] hss;
    logic [CW-1:0] hse;
    logic [CW-1:0] vend;
    logic [CW-1:0] vsize;
    logic [CW-1:0] vss;
    logic [CW-1:0] vse;
  } vid_timing_t;

  typedef struct packed {
    logic [CDW-1:0] r;
    logic [CDW-1:0] g;
    logic [CDW-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vid_timing_gen_if.sv
// Register-field, pixel-FIFO and video-output bundle of the display timing generator.
// VID_TIMING_UNDERFLOW_CNT_EN adds the underflow_cnt signal.
interface vid_timing_gen_if;
  import vid_pkg::*;

  logic           en;
  logic [PDW-1:0] pcnt;
  logic [CW-1:0]  hend, hsize, hss, hse;
  logic [CW-1:0]  vend, vsize, vss, vse;
  logic           fifo_empty;
  logic [CDW-1:0] fifo_r, fifo_g, fifo_b;
  logic           fifo_rd;
  logic           hsync, hblank, vsync, vblank;
  logic [CDW-1:0] R, G, B;
  logic           frame_start;
  logic           underflow;
`ifdef VID_TIMING_UNDERFLOW_CNT_EN
  logic [15:0]    underflow_cnt;

  modport master (
    output en, pcnt, hend, hsize, hss, hse, vend, vsize, vss, vse,
    output fifo_empty, fifo_r, fifo_g, fifo_b,
    input  fifo_rd, hsync, hblank, vsync, vblank, R, G, B, frame_start, underflow,
    input  underflow_cnt
  );
  modport slave (
    input  en, pcnt, hend, hsize, hss, hse, vend, vsize, vss, vse,
    input  fifo_empty, fifo_r, fifo_g, fifo_b,
    output fifo_rd, hsync, hblank, vsync, vblank, R, G, B, frame_start, underflow,
    output underflow_cnt
  );
`else
  modport master (
    output en, pcnt, hend, hsize, hss, hse, vend, vsize, vss, vse,
    output fifo_empty, fifo_r, fifo_g, fifo_b,
    input  fifo_rd, hsync, hblank, vsync, vblank, R, G, B, frame_start, underflow
  );
  modport slave (
    input  en, pcnt, hend, hsize, hss, hse, vend, vsize, vss, vse,
    input  fifo_empty, fifo_r, fifo_g, fifo_b,
    output fifo_rd, hsync, hblank, vsync, vblank, R, G, B, frame_start, underflow
  );
`endif

endinterface

// File: rtl/vid_pix_div.sv
// Pixel-clock divider: one pix_en_c strobe every pcnt_s+1 clocks while enabled.
module vid_pix_div
  import vid_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [PDW-1:0] pcnt_s,
  output logic           pix_en_c
);

  logic [PDW-1:0] div;

  assign pix_en_c = en && (div == pcnt_s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (!en || pix_en_c) begin
      div <= '0;
    end else begin
      div <= div + PDW'(1);
    end
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Display timing generator: frame-shadowed h/v timing, sync/blank decode and FIFO pixel output.
// VID_TIMING_UNDERFLOW_CNT_EN adds a saturating count of underflowed pixels.
module vid_timing_gen
  import vid_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  vid_timing_gen_if.slave vif
);

  vid_timing_t    tim_s;
  vid_timing_t    tim_in;
  logic [PDW-1:0] pcnt_s;
  logic [CW-1:0]  hcnt, vcnt;
  logic           pix_en_c, hwrap_c, vwrap_c, active_c, rd_c, uf_c, fs_c;
  logic           hsync, hblank, vsync, vblank, frame_start, underflow;
  rgb_t           pix;

  always_comb begin
    tim_in       = '0;
    tim_in.hend  = vif.hend;
    tim_in.hsize = vif.hsize;
    tim_in.hss   = vif.hss;
    tim_in.hse   = vif.hse;
    tim_in.vend  = vif.vend;
    tim_in.vsize = vif.vsize;
    tim_in.vss   = vif.vss;
    tim_in.vse   = vif.vse;
  end

  vid_pix_div u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (vif.en),
    .pcnt_s   (pcnt_s),
    .pix_en_c (pix_en_c)
  );

  assign hwrap_c  = hcnt >= tim_s.hend;
  assign vwrap_c  = vcnt >= tim_s.vend;
  assign active_c = (hcnt < tim_s.hsize) && (vcnt < tim_s.vsize);
  assign rd_c     = pix_en_c && active_c && !vif.fifo_empty;
  assign uf_c     = pix_en_c && active_c && vif.fifo_empty;
  assign fs_c     = pix_en_c && (hcnt == '0) && (vcnt == '0);

  // Reset also masks the pop so the FIFOs are untouched while the block is held.
  assign vif.fifo_rd = reset_n && rd_c;

  // Timing fields follow the inputs while disabled, otherwise only at the frame wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tim_s  <= '0;
      pcnt_s <= '0;
    end else if (!vif.en || (pix_en_c && hwrap_c && vwrap_c)) begin
      tim_s  <= tim_in;
      pcnt_s <= vif.pcnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!vif.en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en_c) begin
      if (hwrap_c) begin
        hcnt <= '0;
        vcnt <= vwrap_c ? '0 : vcnt + CW'(1);
      end else begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

  // Output stage: one clock behind the counter position, held between pixel strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= 1'b0;
      hblank      <= 1'b0;
      vsync       <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      pix         <= '0;
    end else if (!vif.en) begin
      hsync       <= 1'b0;
      hblank      <= 1'b0;
      vsync       <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      pix         <= '0;
    end else begin
      frame_start <= fs_c;
      if (uf_c) begin
        underflow <= 1'b1;
      end
      if (pix_en_c) begin
        hsync  <= (hcnt >= tim_s.hss) && (hcnt < tim_s.hse);
        hblank <= hcnt >= tim_s.hsize;
        vsync  <= (vcnt >= tim_s.vss) && (vcnt < tim_s.vse);
        vblank <= vcnt >= tim_s.vsize;
        pix    <= rd_c ? {vif.fifo_r, vif.fifo_g, vif.fifo_b} : '0;
      end
    end
  end

  assign vif.hsync       = hsync;
  assign vif.hblank      = hblank;
  assign vif.vsync       = vsync;
  assign vif.vblank      = vblank;
  assign vif.frame_start = frame_start;
  assign vif.underflow   = underflow;
  assign vif.R           = pix.r;
  assign vif.G           = pix.g;
  assign vif.B           = pix.b;

`ifdef VID_TIMING_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt;
  logic        frame_uf;

  // A frame start clears the count only when the frame just ended was clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uf_cnt   <= '0;
      frame_uf <= 1'b0;
    end else if (!vif.en) begin
      uf_cnt   <= '0;
      frame_uf <= 1'b0;
    end else if (fs_c) begin
      frame_uf <= uf_c;
      if (!frame_uf) begin
        uf_cnt <= uf_c ? 16'd1 : 16'd0;
      end else if (uf_c && (uf_cnt != 16'hFFFF)) begin
        uf_cnt <= uf_cnt + 16'd1;
      end
    end else if (uf_c) begin
      frame_uf <= 1'b1;
      if (uf_cnt != 16'hFFFF) begin
        uf_cnt <= uf_cnt + 16'd1;
      end
    end
  end

  assign vif.underflow_cnt = uf_cnt;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen: per-clock comparison against a frame-arithmetic model.
module tb_vid_timing_gen;
  import vid_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vid_timing_gen_if vif ();

  vid_timing_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vif     (vif)
  );

  int checks   = 0;
  int failures = 0;

  logic [23:0] fifo_q[$];
  bit          refill = 1'b0;

  // Model: pixel index within frame, geometry latched per frame.
  vid_timing_t m_geo;
  int          m_pc, m_sub, m_q, m_n;
  logic        m_uf;
  logic [5:0]  e_flags;   // {hsync, hblank, vsync, vblank, frame_start, underflow}
  logic [23:0] e_rgb;
  int          rd_cnt, hs_cnt, hb_cnt;
  int          fs_log[$];
`ifdef VID_TIMING_UNDERFLOW_CNT_EN
  logic [15:0] m_ucnt;
  logic        m_fuf;
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic vid_timing_t inputs();
    vid_timing_t t;
    t.hend  = vif.hend;  t.hsize = vif.hsize; t.hss = vif.hss; t.hse = vif.hse;
    t.vend  = vif.vend;  t.vsize = vif.vsize; t.vss = vif.vss; t.vse = vif.vse;
    return t;
  endfunction

  task automatic model_clear();
    m_geo   = inputs();
    m_pc    = int'(vif.pcnt);
    m_sub   = 0;
    m_q     = 0;
    m_n     = 0;
    m_uf    = 1'b0;
    e_flags = '0;
    e_rgb   = '0;
`ifdef VID_TIMING_UNDERFLOW_CNT_EN
    m_ucnt  = '0;
    m_fuf   = 1'b0;
`endif
  endtask

  task automatic clear_stats();
    rd_cnt = 0; hs_cnt = 0; hb_cnt = 0;
    fs_log.delete();
  endtask

  task automatic set_geo(input int pc, input int he, input int hsz, input int hs0, input int hs1,
                         input int ve, input int vsz, input int vs0, input int vs1);
    vif.pcnt = PDW'(pc);
    vif.hend = CW'(he); vif.hsize = CW'(hsz); vif.hss = CW'(hs0); vif.hse = CW'(hs1);
    vif.vend = CW'(ve); vif.vsize = CW'(vsz); vif.vss = CW'(vs0); vif.vse = CW'(vs1);
  endtask

  // One clock: present FIFO head, predict, let the edge happen, compare at the negedge.
  task automatic cycle();
    logic        exp_rd, pix, act, empty, was_en;
    logic [23:0] head;
    int          L, F, h, v, edge_no;
    empty = (fifo_q.size() == 0);
    head  = empty ? 24'h5A5A5A : fifo_q[0];
    vif.fifo_empty = empty;
    {vif.fifo_r, vif.fifo_g, vif.fifo_b} = head;
    #1;
    exp_rd     = 1'b0;
    pix        = 1'b0;
    act        = 1'b0;
    was_en     = vif.en;
    edge_no    = m_n;
    e_flags[1] = 1'b0;
    if (!was_en) begin
      model_clear();
    end else begin
      m_n++;
      m_sub++;
      if (m_sub > m_pc) begin
        pix   = 1'b1;
        m_sub = 0;
      end
    end
    if (pix) begin
      L   = int'(m_geo.hend) + 1;
      F   = L * (int'(m_geo.vend) + 1);
      h   = m_q % L;
      v   = m_q / L;
      act = (h < int'(m_geo.hsize)) && (v < int'(m_geo.vsize));
      exp_rd = act && !empty;
      if (act && empty) m_uf = 1'b1;
      e_flags = {(h >= int'(m_geo.hss)) && (h < int'(m_geo.hse)), h >= int'(m_geo.hsize),
                 (v >= int'(m_geo.vss)) && (v < int'(m_geo.vse)), v >= int'(m_geo.vsize),
                 m_q == 0, m_uf};
      e_rgb = exp_rd ? head : 24'h0;
`ifdef VID_TIMING_UNDERFLOW_CNT_EN
      if (m_q == 0) begin
        if (!m_fuf) m_ucnt = '0;
        m_fuf = 1'b0;
      end
      if (act && empty) begin
        m_fuf = 1'b1;
        if (m_ucnt != 16'hFFFF) m_ucnt++;
      end
`endif
      if (m_q == F - 1) begin
        m_q   = 0;
        m_geo = inputs();
        m_pc  = int'(vif.pcnt);
      end else begin
        m_q++;
      end
    end
    checks++;
    if (vif.fifo_rd !== exp_rd) begin
      failures++;
      $display("FAIL fifo_rd edge=%0d got=%b want=%b", edge_no, vif.fifo_rd, exp_rd);
    end
    if (vif.fifo_rd === 1'b1) rd_cnt++;
    @(posedge clk);
    if (exp_rd) void'(fifo_q.pop_front());
    if (refill && fifo_q.size() < 6 && $urandom_range(0, 1) == 1) fifo_q.push_back(24'($urandom));
    @(negedge clk);
    checks++;
    if ({vif.hsync, vif.hblank, vif.vsync, vif.vblank, vif.frame_start, vif.underflow} !== e_flags) begin
      failures++;
      $display("FAIL flags edge=%0d got=%b want=%b", edge_no,
               {vif.hsync, vif.hblank, vif.vsync, vif.vblank, vif.frame_start, vif.underflow}, e_flags);
    end
    checks++;
    if ({vif.R, vif.G, vif.B} !== e_rgb) begin
      failures++;
      $display("FAIL rgb edge=%0d got=%h want=%h", edge_no, {vif.R, vif.G, vif.B}, e_rgb);
    end
`ifdef VID_TIMING_UNDERFLOW_CNT_EN
    checks++;
    if (vif.underflow_cnt !== m_ucnt) begin
      failures++;
      $display("FAIL underflow_cnt edge=%0d got=%0d want=%0d", edge_no, vif.underflow_cnt, m_ucnt);
    end
`endif
    if (was_en) begin
      if (vif.frame_start === 1'b1) fs_log.push_back(edge_no);
      if (vif.hsync === 1'b1) hs_cnt++;
      if (vif.hblank === 1'b1) hb_cnt++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic fill(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      fifo_q.push_back({8'(base + k), 8'(base + k + 100), 8'(base + k + 200)});
    end
  endtask

  // Disabled clock (shadows load), then enable.
  task automatic start();
    vif.en = 1'b0;
    cycle();
    clear_stats();
    vif.en = 1'b1;
  endtask

  task automatic test_reset();
    vif.en = 1'b0;
    set_geo(0, 9, 6, 7, 8, 4, 3, 3, 4);
    vif.fifo_empty = 1'b1;
    {vif.fifo_r, vif.fifo_g, vif.fifo_b} = '0;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #2;
    checks++;
    if ({vif.hsync, vif.hblank, vif.vsync, vif.vblank, vif.frame_start, vif.underflow,
         vif.R, vif.G, vif.B, vif.fifo_rd} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {vif.hsync, vif.hblank, vif.vsync, vif.vblank,
               vif.frame_start, vif.underflow, vif.R, vif.G, vif.B, vif.fifo_rd});
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic_frame();
    int f0, f1;
    refill = 1'b0;
    fifo_q.delete();
    set_geo(0, 9, 6, 7, 8, 4, 3, 3, 4);
    fill(36, 1);
    start();
    run(100);
    f0 = (fs_log.size() > 0) ? fs_log[0] : -1;
    f1 = (fs_log.size() > 1) ? fs_log[1] : -1;
    checks++;
    if (rd_cnt != 36) begin
      failures++;
      $display("FAIL basic_rd_count got=%0d want=36", rd_cnt);
    end
    checks++;
    if (fs_log.size() != 2 || f0 != 0 || f1 != 50) begin
      failures++;
      $display("FAIL basic_frame_start n=%0d first=%0d second=%0d want 2/0/50", fs_log.size(), f0, f1);
    end
    checks++;
    if (hs_cnt != 10) begin
      failures++;
      $display("FAIL basic_hsync_count got=%0d want=10", hs_cnt);
    end
  endtask

  task automatic test_divider();
    int f0, f1;
    refill = 1'b0;
    fifo_q.delete();
    set_geo(2, 9, 6, 7, 8, 4, 3, 3, 4);
    fill(36, 40);
    start();
    run(300);
    f0 = (fs_log.size() > 0) ? fs_log[0] : -1;
    f1 = (fs_log.size() > 1) ? fs_log[1] : -1;
    checks++;
    if (fs_log.size() != 2 || f0 != 2 || f1 != 152) begin
      failures++;
      $display("FAIL div_frame_start n=%0d first=%0d second=%0d want 2/2/152", fs_log.size(), f0, f1);
    end
    checks++;
    if (rd_cnt != 36) begin
      failures++;
      $display("FAIL div_rd_count got=%0d want=36", rd_cnt);
    end
  endtask

  task automatic test_underflow();
    refill = 1'b0;
    fifo_q.delete();
    set_geo(0, 9, 6, 7, 8, 4, 3, 3, 4);
    fill(8, 1);
    start();
    run(13);
    fill(30, 9);
    run(37);
    checks++;
    if (vif.underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky got=%b want=1", vif.underflow);
    end
    checks++;
    if (rd_cnt != 17) begin
      failures++;
      $display("FAIL underflow_rd_count got=%0d want=17", rd_cnt);
    end
`ifdef VID_TIMING_UNDERFLOW_CNT_EN
    checks++;
    if (vif.underflow_cnt !== 16'd1) begin
      failures++;
      $display("FAIL underflow_cnt_one got=%0d want=1", vif.underflow_cnt);
    end
`endif
  endtask

  task automatic test_shadow();
    refill = 1'b0;
    fifo_q.delete();
    set_geo(0, 9, 6, 7, 8, 4, 3, 3, 4);
    fill(36, 60);
    start();
    run(15);
    vif.hsize = CW'(4);
    run(35);
    checks++;
    if (rd_cnt != 18) begin
      failures++;
      $display("FAIL shadow_frame0_rd got=%0d want=18", rd_cnt);
    end
    clear_stats();
    run(50);
    checks++;
    if (rd_cnt != 12) begin
      failures++;
      $display("FAIL shadow_frame1_rd got=%0d want=12", rd_cnt);
    end
    checks++;
    if (hb_cnt != 30) begin
      failures++;
      $display("FAIL shadow_frame1_hblank got=%0d want=30", hb_cnt);
    end
  endtask

  task automatic test_async_reset();
    refill = 1'b0;
    fifo_q.delete();
    set_geo(0, 9, 6, 7, 8, 4, 3, 3, 4);
    fill(36, 1);
    start();
    run(24);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({vif.hsync, vif.hblank, vif.vsync, vif.vblank, vif.frame_start, vif.underflow,
         vif.R, vif.G, vif.B, vif.fifo_rd} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h want=0", {vif.hsync, vif.hblank, vif.vsync,
               vif.vblank, vif.frame_start, vif.underflow, vif.R, vif.G, vif.B, vif.fifo_rd});
    end
    vif.en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    fifo_q.delete();
    cycle();
  endtask

  task automatic test_disable();
    int f0;
    refill = 1'b1;
    fifo_q.delete();
    set_geo(2, 9, 6, 7, 8, 4, 3, 3, 4);
    fill(20, 7);
    start();
    run(40);
    vif.en = 1'b0;
    run(3);
    clear_stats();
    vif.en = 1'b1;
    run(10);
    f0 = (fs_log.size() > 0) ? fs_log[0] : -1;
    checks++;
    if (f0 != 2) begin
      failures++;
      $display("FAIL restart_frame_start got_edge=%0d want_edge=2", f0);
    end
  endtask

  task automatic test_degenerate();
    refill = 1'b1;
    fifo_q.delete();
    set_geo(0, 9, 12, 5, 5, 4, 3, 3, 4);
    fill(6, 90);
    start();
    run(100);
    checks++;
    if (hs_cnt != 0) begin
      failures++;
      $display("FAIL degenerate_hsync got=%0d want=0", hs_cnt);
    end
    checks++;
    if (hb_cnt != 0) begin
      failures++;
      $display("FAIL degenerate_hblank got=%0d want=0", hb_cnt);
    end
  endtask

  task automatic test_random();
    int he, ve, pc;
    refill = 1'b1;
    for (int t = 0; t < 4; t++) begin
      he = int'($urandom_range(12, 3));
      ve = int'($urandom_range(5, 2));
      pc = int'($urandom_range(3, 0));
      set_geo(pc, he, int'($urandom_range(he + 3, 1)), int'($urandom_range(he + 1, 0)),
              int'($urandom_range(he + 1, 0)), ve, int'($urandom_range(ve + 1, 1)),
              int'($urandom_range(ve + 1, 0)), int'($urandom_range(ve + 1, 0)));
      start();
      run(2 * (he + 1) * (ve + 1) * (pc + 1) + 5);
    end
    vif.en = 1'b0;
    cycle();
  endtask

  initial begin
    vif.en = 1'b0;
    clear_stats();
    model_clear();
    test_reset();
    test_basic_frame();
    test_divider();
    test_underflow();
    test_shadow();
    test_async_reset();
    test_disable();
    test_degenerate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
